pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
//   Parametrised hazard and forwarding controller for the pipelined 16-bit core.
//   It keeps a scoreboard of in-flight register writes from EX through WB.
//   Each cycle it returns a per-operand forwarding select and a load-use STALL,
//   so the datapath mux logic is no longer hand-written for a fixed 3-stage pipe.
//   Sits beside the decode stage; the datapath owns the actual operand muxes.
// PARAMETERS
//   ABITS    3  register-number width (2**ABITS architectural registers)
//   STAGES   2  in-flight stages after decode (stage 1 = EX ... stage STAGES = WB), 1..7
//   NSRC     2  source operands per instruction, 1..4
//   LDLAT    2  first stage whose result is valid for a load (1..STAGES)
//   ZEROREG  0  1: register 0 reads as constant, never forwards or stalls
//   CNTBITS  16 width of the stall statistics counter
// PORTS
//   CLK           in   1             clock, all state on posedge
//   RESET         in   1             asynchronous, active-high reset
//   ISSUE_VALID   in   1             decode slot holds a real instruction
//   ISSUE_WE      in   1             issuing instruction writes a register
//   ISSUE_WREGNO  in   ABITS         destination register of issuing instruction
//   ISSUE_ISLOAD  in   1             issuing instruction is LW (late result)
//   SRC_VALID     in   NSRC          per-operand "this operand is read"
//   SRC_REGNO     in   NSRC*ABITS    operand s at [s*ABITS +: ABITS]
//   FLUSH         in   1             kill the instruction in the decode slot (taken branch/JMP)
//   STALL         out  1             hold PC and decode slot this cycle
//   FWDSEL        out  NSRC*3        operand s at [s*3 +: 3]: 0 = regfile, k = stage k result
//   STALLCNT      out  CNTBITS       cycles STALL was asserted, saturating
// BEHAVIOUR
//   - Scoreboard: STAGES entries {valid, we, regno, isload}; entry k = stage k.
//   - RESET (async): all entries invalid, STALLCNT = 0.
//     STALL = 0 and FWDSEL = 0 follow combinationally from the invalid entries.
//   - Each posedge, with RESET low, entries k>=2 take entry k-1 unconditionally.
//     The back end never stalls; the entry leaving WB is dropped.
//   - Entry 1 takes the issue fields when ISSUE_VALID & ~STALL & ~FLUSH.
//     Otherwise entry 1 becomes a bubble (valid = 0).
//   - Match(s,k): SRC_VALID[s] & entry k valid & we & regno == SRC_REGNO[s].
//     With ZEROREG = 1, regno 0 never matches.
//   - FWDSEL[s] = smallest k with Match(s,k), i.e. the youngest writer wins.
//     FWDSEL[s] = 0 if there is no match.
//     Stage STAGES still forwards, because the regfile write lands at the end of that cycle.
//   - Hazard(s): the youngest matching entry has isload = 1 and k < LDLAT.
//     Older matches are ignored, since the younger writer masks them.
//   - STALL = ISSUE_VALID & ~FLUSH & OR_s Hazard(s). Purely combinational, no added latency.
//   - While STALL = 1, FWDSEL is don't-care to the datapath but still computed as above.
//   - FLUSH and hazard in the same cycle: FLUSH wins, STALL = 0, bubble inserted.
//   - STALLCNT increments on each posedge where STALL = 1 and saturates at all ones (no wrap).
//   - Repeated stalls: the bubble advances each cycle and the load moves toward LDLAT.
//     STALL drops on its own after (LDLAT - k) cycles; there is no deadlock.
//   - RESET mid-operation: all in-flight writers are forgotten immediately.
//     This has effect the same cycle, asynchronously.
//   - ISSUE_WE = 0 instructions occupy an entry with we = 0. They never forward or stall.
// TESTING
//   1. Reset, defaults: ADD r3 issued, then ADD reading r3 -> FWDSEL[0]=1, STALL=0.
//      One bubble later -> FWDSEL=2. Two bubbles later -> FWDSEL=0.
//   2. Load-use: LW r2, then ADD r2 -> STALL=1 for exactly 1 cycle, STALLCNT=1.
//      The ADD then issues with FWDSEL=2.
//   3. Youngest wins: ADDI r4, then LW r4, then read r4 -> stall, since the LW is in stage 1.
//      Reverse order (LW then ADDI) -> FWDSEL=1, no stall.
//   4. FLUSH while load-use hazard present -> STALL=0 and entry 1 bubbles.
//      Next-cycle read of the flushed dest -> FWDSEL=0.
//   5. ZEROREG=1: write r0 then read r0 -> FWDSEL=0.
//      CNTBITS=2: 5 stall cycles -> STALLCNT=3.
//   6. STAGES=4, LDLAT=3: LW r1, then read r1 -> 2 stall cycles, then FWDSEL=3.
//      Assert RESET during the first stall -> STALL=0 at once, FWDSEL=0.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
`timescale 1ns/1ps
// Hazard and forwarding controller: a scoreboard of in-flight register writers from EX to WB
// drives per-operand forwarding selects and the load-use stall for the decode stage.
module pipe_hazard_unit #(
    parameter int ABITS   = 3,
    parameter int STAGES  = 2,
    parameter int NSRC    = 2,
    parameter int LDLAT   = 2,
    parameter int ZEROREG = 0,
    parameter int CNTBITS = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ISSUE_VALID,
    input  logic                    ISSUE_WE,
    input  logic [ABITS-1:0]        ISSUE_WREGNO,
    input  logic                    ISSUE_ISLOAD,
    input  logic [NSRC-1:0]         SRC_VALID,
    input  logic [NSRC*ABITS-1:0]   SRC_REGNO,
    input  logic                    FLUSH,
    output logic                    STALL,
    output logic [NSRC*3-1:0]       FWDSEL,
    output logic [CNTBITS-1:0]      STALLCNT
);

    // Issue handshake: the decode slot is accepted into stage 1 on a posedge
    // where ISSUE_VALID & ~STALL & ~FLUSH; every other cycle inserts a bubble.
    logic [STAGES:1]    vld_q, vld_d;
    logic [STAGES:1]    we_q, we_d;
    logic [STAGES:1]    ld_q, ld_d;
    logic [ABITS-1:0]   rn_q [1:STAGES];
    logic [ABITS-1:0]   rn_d [1:STAGES];
    logic [CNTBITS-1:0] cnt_q, cnt_d;
    logic [NSRC-1:0]    hazard;

    // Scan oldest to youngest so the youngest matching writer overrides the rest.
    always_comb begin
        FWDSEL = '0;
        hazard = '0;
        for (int s = 0; s < NSRC; s++) begin
            for (int k = STAGES; k >= 1; k--) begin
                if (SRC_VALID[s] && vld_q[k] && we_q[k] &&
                    (rn_q[k] == SRC_REGNO[s*ABITS +: ABITS]) &&
                    !((ZEROREG != 0) && (rn_q[k] == '0))) begin
                    FWDSEL[s*3 +: 3] = 3'(k);
                    hazard[s]        = ld_q[k] && (k < LDLAT);
                end
            end
        end
        STALL = ISSUE_VALID && !FLUSH && (|hazard);
    end

    always_comb begin
        vld_d = vld_q;
        we_d  = we_q;
        ld_d  = ld_q;
        rn_d  = rn_q;
        for (int k = STAGES; k >= 2; k--) begin
            vld_d[k] = vld_q[k-1];
            we_d[k]  = we_q[k-1];
            ld_d[k]  = ld_q[k-1];
            rn_d[k]  = rn_q[k-1];
        end
        vld_d[1] = ISSUE_VALID && !STALL && !FLUSH;
        we_d[1]  = ISSUE_WE;
        ld_d[1]  = ISSUE_ISLOAD;
        rn_d[1]  = ISSUE_WREGNO;
        cnt_d    = cnt_q;
        if (STALL && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTBITS'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vld_q <= '0;
            we_q  <= '0;
            ld_q  <= '0;
            cnt_q <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                rn_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            we_q  <= we_d;
            ld_q  <= ld_d;
            cnt_q <= cnt_d;
            for (int k = 1; k <= STAGES; k++) begin
                rn_q[k] <= rn_d[k];
            end
        end
    end

    assign STALLCNT = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
`timescale 1ns/1ps
// Bench for pipe_hazard_unit: three parameterisations share one stimulus stream and are
// checked against directed vector tables, hand sequences and a history-based reference model.
module tb_pipe_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv, iwe, ild, fl;
  logic [2:0] iwr;
  logic [1:0] sv;
  logic [5:0] sr;

  logic st0, st1, st2;
  logic [5:0] fw0, fw1, fw2;
  logic [15:0] cn0, cn2;
  logic [1:0] cn1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [22:0] exp_q[$];

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // default: STAGES=2 LDLAT=2
  pipe_hazard_unit dut0 (
    .CLK(clk), .RESET(rst), .ISSUE_VALID(iv), .ISSUE_WE(iwe), .ISSUE_WREGNO(iwr),
    .ISSUE_ISLOAD(ild), .SRC_VALID(sv), .SRC_REGNO(sr), .FLUSH(fl),
    .STALL(st0), .FWDSEL(fw0), .STALLCNT(cn0));

  pipe_hazard_unit #(.ZEROREG(1), .CNTBITS(2)) dut1 (
    .CLK(clk), .RESET(rst), .ISSUE_VALID(iv), .ISSUE_WE(iwe), .ISSUE_WREGNO(iwr),
    .ISSUE_ISLOAD(ild), .SRC_VALID(sv), .SRC_REGNO(sr), .FLUSH(fl),
    .STALL(st1), .FWDSEL(fw1), .STALLCNT(cn1));

  pipe_hazard_unit #(.STAGES(4), .LDLAT(3)) dut2 (
    .CLK(clk), .RESET(rst), .ISSUE_VALID(iv), .ISSUE_WE(iwe), .ISSUE_WREGNO(iwr),
    .ISSUE_ISLOAD(ild), .SRC_VALID(sv), .SRC_REGNO(sr), .FLUSH(fl),
    .STALL(st2), .FWDSEL(fw2), .STALLCNT(cn2));

  // ---------------- reference model: history of issue slots ----------------
  typedef struct packed {
    logic       v;
    logic       we;
    logic [2:0] rn;
    logic       ld;
  } ent_t;

  ent_t hist [3][1:7];
  int p_st  [3] = '{2, 2, 4};
  int p_ll  [3] = '{2, 2, 3};
  int p_zr  [3] = '{0, 1, 0};
  int p_max [3] = '{65535, 3, 65535};
  int mcnt  [3];

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      mcnt[m] = 0;
      for (int k = 1; k <= 7; k++) hist[m][k] = '0;
    end
  endtask

  // The youngest earlier instruction that writes the operand supplies it;
  // it causes a stall only if it is a load whose data is not yet ready.
  task automatic model_eval(input int m, output logic es, output logic [5:0] ef);
    logic hz;
    logic found;
    ent_t e;
    hz = 1'b0;
    ef = '0;
    for (int s = 0; s < 2; s++) begin
      found = 1'b0;
      for (int k = 1; k <= p_st[m]; k++) begin
        e = hist[m][k];
        if (!found && sv[s] && e.v && e.we && (e.rn == sr[s*3 +: 3]) &&
            !(p_zr[m] == 1 && e.rn == 3'd0)) begin
          found = 1'b1;
          ef[s*3 +: 3] = 3'(k);
          if (e.ld && (k < p_ll[m])) hz = 1'b1;
        end
      end
    end
    es = iv && !fl && hz;
  endtask

  task automatic model_clock(input int m, input logic es);
    ent_t e;
    for (int k = 7; k >= 2; k--) hist[m][k] = hist[m][k-1];
    e.v  = iv && !es && !fl;
    e.we = iwe;
    e.rn = iwr;
    e.ld = ild;
    hist[m][1] = e;
    if (es && (mcnt[m] < p_max[m])) mcnt[m]++;
  endtask

  function automatic logic [22:0] act_word(input int m);
    case (m)
      0:       return {st0, fw0, cn0};
      1:       return {st1, fw1, 14'd0, cn1};
      default: return {st2, fw2, cn2};
    endcase
  endfunction

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a_iv, input logic a_we, input logic [2:0] a_wr,
                       input logic a_ld, input logic [1:0] a_sv, input logic [5:0] a_sr,
                       input logic a_fl);
    iv = a_iv; iwe = a_we; iwr = a_wr; ild = a_ld; sv = a_sv; sr = a_sr; fl = a_fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset stall0", 32'(st0), 0);
    chk("reset fwd0", 32'(fw0), 0);
    chk("reset cnt0", 32'(cn0), 0);
    chk("reset stall1", 32'(st1), 0);
    chk("reset cnt1", 32'(cn1), 0);
    chk("reset stall2", 32'(st2), 0);
    chk("reset fwd2", 32'(fw2), 0);
    tick();
  endtask

  // ---------------- directed vector table (default parameters) ----------------
  typedef struct {
    logic       iv, we;
    logic [2:0] wr;
    logic       ld;
    logic [1:0] sv;
    logic [5:0] sr;
    logic       fl;
    logic       st;
    logic [5:0] fw;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic a_iv, input logic a_we, input logic [2:0] a_wr,
                              input logic a_ld, input logic [1:0] a_sv, input logic [5:0] a_sr,
                              input logic a_fl, input logic e_st, input logic [5:0] e_fw,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.iv = a_iv; v.we = a_we; v.wr = a_wr; v.ld = a_ld; v.sv = a_sv; v.sr = a_sr;
    v.fl = a_fl; v.st = e_st; v.fw = e_fw; v.cnt = e_cnt;
    return v;
  endfunction

  initial begin
    logic es [3];
    logic [5:0] ef;
    logic [22:0] ew;

    drive(0, 0, 0, 0, 0, 0, 0);
    // ADD r3 then readers at distance 1, 2, 3; src1 path
    tbl[0]  = mk(1, 1, 3'd3, 0, 2'b00, 6'o00, 0, 0, 6'o00, 0);
    tbl[1]  = mk(0, 0, 3'd0, 0, 2'b01, 6'o03, 0, 0, 6'o01, 0);
    tbl[2]  = mk(0, 0, 3'd0, 0, 2'b01, 6'o03, 0, 0, 6'o02, 0);
    tbl[3]  = mk(0, 0, 3'd0, 0, 2'b01, 6'o03, 0, 0, 6'o00, 0);
    tbl[4]  = mk(1, 1, 3'd6, 0, 2'b00, 6'o00, 0, 0, 6'o00, 0);
    tbl[5]  = mk(0, 0, 3'd0, 0, 2'b10, 6'o60, 0, 0, 6'o10, 0);
    // load-use: LW r2, dependent ADD stalls once then forwards from stage 2
    tbl[6]  = mk(1, 1, 3'd2, 1, 2'b00, 6'o00, 0, 0, 6'o00, 0);
    tbl[7]  = mk(1, 1, 3'd7, 0, 2'b01, 6'o02, 0, 1, 6'o01, 0);
    tbl[8]  = mk(1, 1, 3'd7, 0, 2'b01, 6'o02, 0, 0, 6'o02, 1);
    tbl[9]  = mk(0, 0, 3'd0, 0, 2'b00, 6'o00, 0, 0, 6'o00, 1);
    // youngest wins: ADDI r4, LW r4, read r4 -> stall
    tbl[10] = mk(1, 1, 3'd4, 0, 2'b00, 6'o00, 0, 0, 6'o00, 1);
    tbl[11] = mk(1, 1, 3'd4, 1, 2'b00, 6'o00, 0, 0, 6'o00, 1);
    tbl[12] = mk(1, 0, 3'd0, 0, 2'b01, 6'o04, 0, 1, 6'o01, 1);
    tbl[13] = mk(1, 0, 3'd0, 0, 2'b01, 6'o04, 0, 0, 6'o02, 2);
    // reverse: LW r4, ADDI r4, read r4 -> forward from ADDI, no stall
    tbl[14] = mk(1, 1, 3'd4, 1, 2'b00, 6'o00, 0, 0, 6'o00, 2);
    tbl[15] = mk(1, 1, 3'd4, 0, 2'b00, 6'o00, 0, 0, 6'o00, 2);
    tbl[16] = mk(1, 0, 3'd0, 0, 2'b01, 6'o04, 0, 0, 6'o01, 2);
    // flush during a load-use hazard; flushed writer of r1 never forwards
    tbl[17] = mk(1, 1, 3'd5, 1, 2'b00, 6'o00, 0, 0, 6'o00, 2);
    tbl[18] = mk(1, 1, 3'd1, 0, 2'b01, 6'o05, 1, 0, 6'o01, 2);
    tbl[19] = mk(0, 0, 3'd0, 0, 2'b11, 6'o51, 0, 0, 6'o20, 2);
    // hazard without a valid issue does not stall
    tbl[20] = mk(1, 1, 3'd2, 1, 2'b00, 6'o00, 0, 0, 6'o00, 2);
    tbl[21] = mk(0, 0, 3'd0, 0, 2'b01, 6'o02, 0, 0, 6'o01, 2);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].iv, tbl[i].we, tbl[i].wr, tbl[i].ld, tbl[i].sv, tbl[i].sr, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d stall", i), 32'(st0), 32'(tbl[i].st));
      chk($sformatf("vec%0d fwdsel", i), 32'(fw0), 32'(tbl[i].fw));
      chk($sformatf("vec%0d stallcnt", i), 32'(cn0), 32'(tbl[i].cnt));
      tick();
    end

    // ZEROREG=1 and a 2-bit saturating counter
    do_reset();
    drive(1, 1, 3'd0, 0, 2'b00, 6'o00, 0);
    tick();
    drive(0, 0, 3'd0, 0, 2'b01, 6'o00, 0);
    @(negedge clk);
    chk("zeroreg fwd r0", 32'(fw1), 0);
    chk("nonzeroreg fwd r0", 32'(fw0), 1);
    tick();
    for (int r = 0; r < 5; r++) begin
      drive(1, 1, 3'd2, 1, 2'b00, 6'o00, 0);
      tick();
      drive(1, 0, 3'd0, 0, 2'b01, 6'o02, 0);
      @(negedge clk);
      chk($sformatf("sat rep%0d stall", r), 32'(st1), 1);
      tick();
      tick();
    end
    drive(0, 0, 3'd0, 0, 2'b00, 6'o00, 0);
    @(negedge clk);
    chk("cnt saturated", 32'(cn1), 3);
    chk("cnt wide", 32'(cn0), 5);
    tick();

    // STAGES=4 LDLAT=3: two stall cycles, then forward from stage 3
    do_reset();
    drive(1, 1, 3'd1, 1, 2'b00, 6'o00, 0);
    tick();
    drive(1, 0, 3'd0, 0, 2'b01, 6'o01, 0);
    @(negedge clk);
    chk("s4 stall c1", 32'(st2), 1);
    chk("s4 fwd c1", 32'(fw2), 1);
    tick();
    @(negedge clk);
    chk("s4 stall c2", 32'(st2), 1);
    chk("s4 fwd c2", 32'(fw2), 2);
    tick();
    @(negedge clk);
    chk("s4 stall c3", 32'(st2), 0);
    chk("s4 fwd c3", 32'(fw2), 3);
    tick();
    drive(1, 1, 3'd1, 1, 2'b00, 6'o00, 0);
    @(negedge clk);
    chk("s4 cnt", 32'(cn2), 2);
    tick();
    drive(1, 0, 3'd0, 0, 2'b01, 6'o01, 0);
    @(negedge clk);
    chk("s4 stall pre-reset", 32'(st2), 1);
    #1 rst = 1'b1;
    #1;
    chk("async reset stall", 32'(st2), 0);
    chk("async reset fwd", 32'(fw2), 0);
    chk("async reset cnt", 32'(cn2), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // randomized traffic against the reference model for all three configurations
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
            2'($urandom_range(0, 3)),
            {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))},
            ($urandom_range(0, 7) == 0));
      @(negedge clk);
      for (int m = 0; m < 3; m++) begin
        model_eval(m, es[m], ef);
        exp_q.push_back({es[m], ef, 16'(mcnt[m])});
      end
      for (int m = 0; m < 3; m++) begin
        ew = exp_q.pop_front();
        chk($sformatf("rand c%0d m%0d", c, m), 32'(act_word(m)), 32'(ew));
      end
      @(posedge clk);
      for (int m = 0; m < 3; m++) model_clock(m, es[m]);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
